// File: rtl/wm_fifo_pkg.sv
// Shared constants and width helper for the watermark FIFO.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package wm_fifo_pkg;

    localparam int WM_FIFO_DEPTH      = 8;
    localparam int WM_FIFO_DATA_WIDTH = 8;

    // Level/threshold/pointer width: one extra bit so that a count of DEPTH
    // is representable and pointers carry a wrap bit above the index.
    function automatic int calc_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wm_fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Latency: a write is readable on the cycle after its rising edge.
// Backpressure: none; the caller only asserts we when a slot is free.
//
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module wm_fifo_mem
    import wm_fifo_pkg::*;
#(
    parameter int DEPTH      = WM_FIFO_DEPTH,
    parameter int DATA_WIDTH = WM_FIFO_DATA_WIDTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wm_fifo.sv
// Watermark FIFO: first-word-fall-through queue with level, almost_full /
// almost_empty watermarks, sticky watermark irq and optional sticky errors.
// Latency: a push into an empty FIFO shows rd_valid the next cycle.
// Backpressure: wr_ready = !full; a full FIFO refuses writes but still pops.
//
// Ports: clk, rst_n (sync, active-low), flush; wr_valid/wr_ready/wr_data;
// rd_valid/rd_ready/rd_data; level; hi_thresh/lo_thresh; almost_full,
// almost_empty; irq/irq_clr; ovf_err/unf_err/err_clr.
// Build option: define WM_FIFO_ERR_EN to enable ovf_err/unf_err; when it is
// undefined both flags read 0 and err_clr has no effect.
module wm_fifo
    import wm_fifo_pkg::*;
#(
    parameter int DEPTH      = WM_FIFO_DEPTH,
    parameter int DATA_WIDTH = WM_FIFO_DATA_WIDTH,
    localparam int CW        = calc_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         level,
    input  logic [CW-1:0]         hi_thresh,
    input  logic [CW-1:0]         lo_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  irq,
    input  logic                  irq_clr,
    output logic                  ovf_err,
    output logic                  unf_err,
    input  logic                  err_clr
);

    localparam int AW = CW - 1;

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] level_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          af_q;
    logic          irq_q;
    logic          irq_set;
    logic          mem_we;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Pointers and level: reset, then flush, dominate any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + CW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - CW'(1);
            end
        end
    end

    assign level = level_q;

    // A write swallowed by reset or flush must not land in the array either.
    assign mem_we = push && rst_n && !flush;

    wm_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign almost_full  = (level_q >= hi_thresh);
    assign almost_empty = (level_q <= lo_thresh);

    // Rising edge of almost_full, using the previous cycle's value held in
    // af_q. Flush does not touch this path, so irq survives a flush.
    assign irq_set = almost_full && !af_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            af_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            af_q <= almost_full;
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq = irq_q;

`ifdef WM_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Sticky protocol errors; a new violation beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (rd_ready && !rd_valid) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf_err        = 1'b0;
    assign unf_err        = 1'b0;
`endif

endmodule
